// File: rtl/qphase_to_iq_pkg.sv
// Shared constants for the phase -> I/Q CORDIC: quantized pi values, CORDIC gain, arctangent table, FSM states.
// Angles are Q.BITS radians; the arctangent table is quantized at the internal (QBITS+GUARD) precision.
package qphase_to_iq_pkg;

    localparam int  BITS          = 10;
    localparam real PI_REAL       = 3.14159265358979;
    localparam real CORDIC_K_REAL = 0.6072529350;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_WRITE
    } state_t;

    // Truncating quantization, matching how the upstream arctan stage derives its pi constants.
    function automatic int quantize_f(real v, int bits);
        return $rtoi(v * real'(longint'(1) << bits));
    endfunction

    function automatic int round_pos_f(real v, int bits);
        return $rtoi(v * real'(longint'(1) << bits) + 0.5);
    endfunction

    localparam int PI_Q      = quantize_f(PI_REAL, BITS);
    localparam int HALF_PI_Q = quantize_f(PI_REAL / 2.0, BITS);
    localparam int TWO_PI_Q  = 2 * PI_Q;

    function automatic real atan_pow2(int i);
        case (i)
            0:       return 0.7853981633974483;
            1:       return 0.4636476090008061;
            2:       return 0.24497866312686414;
            3:       return 0.12435499454676144;
            4:       return 0.06241880999595735;
            5:       return 0.031239833430268277;
            6:       return 0.015623728620476831;
            7:       return 0.007812341060101111;
            8:       return 0.0039062301319669718;
            9:       return 0.0019531225164788188;
            10:      return 0.0009765621895593195;
            11:      return 0.0004882812111948983;
            12:      return 0.00024414062014936177;
            13:      return 0.00012207031189367021;
            14:      return 0.00006103515617420877;
            default: return 0.000030517578115526096;
        endcase
    endfunction

    function automatic logic [15:0][31:0] atan_table(int bits);
        logic [15:0][31:0] t;
        for (int i = 0; i < 16; i++) begin
            t[i] = 32'(round_pos_f(atan_pow2(i), bits));
        end
        return t;
    endfunction

endpackage

// File: rtl/qphase_to_iq_rot.sv
// One CORDIC micro-rotation in rotation mode: steer (x,y) toward the residual angle z by +/-atan(2^-i).
// Purely combinational; the caller registers the result.
module cordic_rot_stage (
    input  logic signed [31:0] x,
    input  logic signed [31:0] y,
    input  logic signed [31:0] z,
    input  logic        [4:0]  i,
    input  logic signed [31:0] atan_i,
    output logic signed [31:0] x_nx,
    output logic signed [31:0] y_nx,
    output logic signed [31:0] z_nx
);

    logic signed [31:0] x_sh;
    logic signed [31:0] y_sh;

    assign x_sh = x >>> i;
    assign y_sh = y >>> i;

    always_comb begin
        if (z >= 0) begin
            x_nx = x - y_sh;
            y_nx = y + x_sh;
            z_nx = z - atan_i;
        end else begin
            x_nx = x + y_sh;
            y_nx = y - x_sh;
            z_nx = z + atan_i;
        end
    end

endmodule

// File: rtl/qphase_to_iq.sv
// Phase word -> (cos, sin) via iterative CORDIC, one sample per ITERS+2 cycles, I/Q written in lockstep.
// Optional QPHASE_ACCUM_EN: input is a phase increment integrated into a wrapped phase accumulator.
module qphase_to_iq
    import qphase_to_iq_pkg::*;
#(
    parameter int QBITS = BITS,
    parameter int ITERS = 14,
    parameter int GUARD = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               in_rd_en,
    input  logic               in_empty,
    input  logic signed [31:0] in_dout,
    output logic               outI_wr_en,
    input  logic               outI_full,
    output logic signed [31:0] outI_din,
    output logic               outQ_wr_en,
    input  logic               outQ_full,
    output logic signed [31:0] outQ_din
);

    localparam logic signed [31:0] PI_L     = 32'(quantize_f(PI_REAL, QBITS));
    localparam logic signed [31:0] HALF_L   = 32'(quantize_f(PI_REAL / 2.0, QBITS));
    localparam logic signed [31:0] K_L      = 32'(round_pos_f(CORDIC_K_REAL, QBITS + GUARD));
    localparam logic signed [31:0] HALF_LSB = 32'sd1 <<< (GUARD - 1);
    localparam logic [15:0][31:0]  ATAN_L   = atan_table(QBITS + GUARD);

    state_t             state, state_nx;
    logic signed [31:0] x, y, z;
    logic signed [31:0] x_nx, y_nx, z_nx;
    logic        [4:0]  iter;
    logic               neg;
    logic               wr;
    logic signed [31:0] phase;
    logic signed [31:0] z_ld;
    logic               neg_ld;
    logic signed [31:0] i_rnd, q_rnd;

`ifdef QPHASE_ACCUM_EN
    localparam logic signed [31:0] TWO_PI_L = 2 * PI_L;
    logic signed [31:0] acc;
    logic signed [31:0] acc_sum;

    always_comb begin
        acc_sum = acc + in_dout;
        phase   = acc_sum;
        if (acc_sum > PI_L) begin
            phase = acc_sum - TWO_PI_L;
        end else if (acc_sum < -PI_L) begin
            phase = acc_sum + TWO_PI_L;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (in_rd_en) begin
            acc <= phase;
        end
    end
`else
    assign phase = in_dout;
`endif

    // Fold outer half-plane onto [-pi/2, pi/2]; the rotation by pi becomes a final negation.
    always_comb begin
        z_ld   = phase;
        neg_ld = 1'b0;
        if (phase > HALF_L) begin
            z_ld   = phase - PI_L;
            neg_ld = 1'b1;
        end else if (phase < -HALF_L) begin
            z_ld   = phase + PI_L;
            neg_ld = 1'b1;
        end
    end

    cordic_rot_stage u_rot (
        .x      (x),
        .y      (y),
        .z      (z),
        .i      (iter),
        .atan_i (ATAN_L[iter[3:0]]),
        .x_nx   (x_nx),
        .y_nx   (y_nx),
        .z_nx   (z_nx)
    );

    always_comb begin
        state_nx = state;
        in_rd_en = 1'b0;
        wr       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!in_empty && !reset) begin
                    in_rd_en = 1'b1;
                    state_nx = S_ROT;
                end
            end
            S_ROT: begin
                if (iter == 5'(ITERS - 1)) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!outI_full && !outQ_full) begin
                    wr       = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            iter  <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_nx;
            if (in_rd_en) begin
                x    <= K_L;
                y    <= '0;
                z    <= z_ld <<< GUARD;
                neg  <= neg_ld;
                iter <= '0;
            end else if (state == S_ROT) begin
                x    <= x_nx;
                y    <= y_nx;
                z    <= z_nx;
                iter <= iter + 5'd1;
            end
        end
    end

    assign i_rnd = (x + HALF_LSB) >>> GUARD;
    assign q_rnd = (y + HALF_LSB) >>> GUARD;

    assign outI_wr_en = wr;
    assign outQ_wr_en = wr;
    assign outI_din   = wr ? (neg ? -i_rnd : i_rnd) : '0;
    assign outQ_din   = wr ? (neg ? -q_rnd : q_rnd) : '0;

endmodule

// File: tb/tb_qphase_to_iq.sv
// Bench for qphase_to_iq: FIFO emulation, trig reference model with +/-2 LSB tolerance, per-cycle handshake checks.
module tb_qphase_to_iq;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_rd_en;
    logic               in_empty = 1'b1;
    logic signed [31:0] in_dout = '0;
    logic               outI_wr_en;
    logic               outI_full = 1'b0;
    logic signed [31:0] outI_din;
    logic               outQ_wr_en;
    logic               outQ_full = 1'b0;
    logic signed [31:0] outQ_din;

    always #5 clock = ~clock;

    qphase_to_iq dut (
        .clock      (clock),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .outI_wr_en (outI_wr_en),
        .outI_full  (outI_full),
        .outI_din   (outI_din),
        .outQ_wr_en (outQ_wr_en),
        .outQ_full  (outQ_full),
        .outQ_din   (outQ_din)
    );

    typedef struct { int val; bit lit; int li; int lq; } src_t;
    typedef struct { int phase; int pop; bit lit; int li; int lq; } ent_t;

    src_t fifo[$];
    ent_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   pend = 0;
    bit   nf_i = 0;
    bit   nf_q = 0;
`ifdef QPHASE_ACCUM_EN
    int   acc_m = 0;
`endif

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, got, want);
        end
    endtask

    task automatic chk_tol(string name, int phase, int got, int want);
        checks++;
        if (got > want + 2 || got < want - 2) begin
            errors++;
            $display("FAIL %s phase %0d got %0d want %0d+-2", name, phase, got, want);
        end
    endtask

    function automatic int ideal_cos(int p);
        return int'($cos(real'(p) / 1024.0) * 1024.0);
    endfunction

    function automatic int ideal_sin(int p);
        return int'($sin(real'(p) / 1024.0) * 1024.0);
    endfunction

    function automatic int model_phase(int v);
`ifdef QPHASE_ACCUM_EN
        acc_m = acc_m + v;
        if (acc_m > 3216) acc_m = acc_m - 6432;
        else if (acc_m < -3216) acc_m = acc_m + 6432;
        return acc_m;
`else
        return v;
`endif
    endfunction

    task automatic push(int v, bit lit, int li, int lq);
        src_t s;
        s.val = v; s.lit = lit; s.li = li; s.lq = lq;
        fifo.push_back(s);
    endtask

    task automatic check_cycle();
        ent_t e;
        bit   exp_wr;
        chk("rd_en", int'(in_rd_en), int'(expq.size() == 0 && fifo.size() != 0));
        if (in_rd_en && fifo.size() != 0) begin
            e.phase = model_phase(fifo[0].val);
            e.pop   = cyc;
            e.lit   = fifo[0].lit;
            e.li    = fifo[0].li;
            e.lq    = fifo[0].lq;
            expq.push_back(e);
            pend = 1'b1;
        end
        exp_wr = expq.size() != 0 && (cyc - expq[0].pop >= 15) && !nf_i && !nf_q;
        chk("I_wr_en", int'(outI_wr_en), int'(exp_wr));
        chk("Q_wr_en", int'(outQ_wr_en), int'(exp_wr));
        if (exp_wr) begin
            e = expq.pop_front();
            chk_tol("I_model", e.phase, outI_din, ideal_cos(e.phase));
            chk_tol("Q_model", e.phase, outQ_din, ideal_sin(e.phase));
            if (e.lit) begin
                chk_tol("I_literal", e.phase, outI_din, e.li);
                chk_tol("Q_literal", e.phase, outQ_din, e.lq);
                chk("latency", cyc - e.pop, 15);
            end
        end else begin
            chk("I_din_idle", outI_din, 0);
            chk("Q_din_idle", outQ_din, 0);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        cyc++;
        if (pend) begin
            void'(fifo.pop_front());
            pend = 1'b0;
        end
        in_empty  = (fifo.size() == 0);
        in_dout   = (fifo.size() != 0) ? fifo[0].val : 0;
        outI_full = nf_i;
        outQ_full = nf_q;
        #1;
        if (reset) begin
            chk("rst_rd_en", int'(in_rd_en), 0);
            chk("rst_wr_en", int'(outI_wr_en | outQ_wr_en), 0);
            chk("rst_din", int'(outI_din != 0 || outQ_din != 0), 0);
        end else begin
            check_cycle();
        end
    endtask

    task automatic drain(bit rnd, int budget);
        int n = 0;
        while ((fifo.size() != 0 || expq.size() != 0) && n < budget) begin
            if (rnd) begin
                nf_i = ($urandom_range(0, 7) == 0);
                nf_q = ($urandom_range(0, 7) == 0);
            end
            cycle();
            n++;
        end
        nf_i = 1'b0;
        nf_q = 1'b0;
        cycle();
        chk("drain_done", int'(n < budget), 1);
    endtask

    task automatic wait_pop(int budget);
        int n = 0;
        while (expq.size() == 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("pop_seen", int'(expq.size() != 0), 1);
    endtask

    initial begin
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

`ifdef QPHASE_ACCUM_EN
        push(804, 1, 724, 724);
        push(804, 1, 0, 1024);
        push(804, 1, -724, 724);
        push(804, 1, -1024, 0);
        push(804, 1, -724, -724);
`else
        push(0, 1, 1024, 0);
        push(1608, 1, 0, 1024);
        push(-1608, 1, 0, -1024);
        push(2413, 1, -724, 724);
        push(-3216, 1, -1024, 0);
`endif
        drain(1'b0, 200);

        // Back-pressure on the Q FIFO only: nothing may be written to either side.
        push(804, 0, 0, 0);
        wait_pop(10);
        nf_q = 1'b1;
        push(-500, 0, 0, 0);
        repeat (21) cycle();
        nf_q = 1'b0;
        drain(1'b0, 100);

        // Reset in the middle of the rotation phase; the aborted sample must never appear.
        push(300, 0, 0, 0);
        wait_pop(10);
        repeat (3) cycle();
        reset = 1'b1;
        #1;
        chk("midrst_wr_en", int'(outI_wr_en | outQ_wr_en), 0);
        chk("midrst_din", int'(outI_din != 0 || outQ_din != 0), 0);
        expq.delete();
        pend = 1'b0;
`ifdef QPHASE_ACCUM_EN
        acc_m = 0;
`endif
        repeat (2) cycle();
        reset = 1'b0;
        push(804, 1, 724, 724);
        drain(1'b0, 100);

        for (int k = 0; k < 60; k++) begin
            push(int'($urandom_range(0, 6432)) - 3216, 0, 0, 0);
        end
        drain(1'b1, 5000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
